// File: rtl/test_pkg_a.sv
`default_nettype none
// ============================================================================
// Module      : test_pkg_a
// Description : Shared hero-bus types: cycle encoding, beat record and the
//               write-receiver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package test_pkg_a;

    localparam int HERO_WIDTH = 32;

    // Hero cycle type carried alongside every data beat; code 3 is reserved
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2,
        RSVD  = 2'd3
    } cycle_type_e;

    // One buffered beat: payload plus end-of-write marker
    typedef struct packed {
        logic [HERO_WIDTH-1:0] data;
        logic                  last;
    } hero_write_t;

    // Write receiver sequencing
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CLOSE = 2'd2
    } rx_state_e;

    // True for the two cycle types that carry a beat
    function automatic logic is_beat(input cycle_type_e cyc);
        return (cyc == VALID) || (cyc == DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hero_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hero_rx_fifo
// Description : Count-based circular beat buffer (data + last flag). The head
//               is only visible once a push has been registered, so a beat
//               never bypasses the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module hero_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // Guard against pushing into a full or popping an empty buffer
    assign w_push = push & ~full;
    assign w_pop  = pop  & ~empty;

    assign full  = (r_count == c_full_count);
    assign empty = (r_count == '0);

    // Head is forced to zero when nothing is stored so reset leaves clean outputs
    assign {head_data, head_last} = empty ? (WIDTH + 1)'(0) : r_mem[r_rptr];

    // Storage array: written on every accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {push_data, push_last};
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hero_write_rx.sv
`default_nettype none
// ============================================================================
// Module      : hero_write_rx
// Description : Hero-bus write receiver. Accepts VALID/DONE beats into a
//               buffer, tracks the beat count of each write, pulses on write
//               completion and flags protocol and beat-limit errors.
// Revision    : 1.0 - initial release
// ============================================================================
module hero_write_rx #(
    parameter int HERO_WIDTH = test_pkg_a::HERO_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  test_pkg_a::cycle_type_e          in_cycle,
    input  logic [HERO_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [HERO_WIDTH-1:0]            out_data,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             done_pulse,
    output logic [$clog2(MAX_BEATS+1)-1:0]   beat_count,
    output logic                             err_proto,
    output logic                             err_overflow
);

    import test_pkg_a::*;

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] c_max_beats = CW'(MAX_BEATS);

    rx_state_e       r_state;
    logic [CW-1:0]   r_beats;
    logic [CW-1:0]   w_beats_nxt;
    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_is_done;

    // Ready drops during reset, while the buffer is full and while closing a write
    assign in_ready    = ~rst & ~w_full & (r_state != S_CLOSE);
    assign w_accept    = in_ready & is_beat(in_cycle);
    assign w_is_done   = (in_cycle == DONE);
    assign w_beats_nxt = (r_beats == c_max_beats) ? r_beats : r_beats + CW'(1);
    assign out_valid   = ~w_empty;

    hero_rx_fifo #(
        .WIDTH (HERO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data (in_data),
        .push_last (w_is_done),
        .pop       (out_valid & out_ready),
        .full      (w_full),
        .empty     (w_empty),
        .head_data (out_data),
        .head_last (out_last)
    );

    // Write sequencing, beat counting and registered completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_beats      <= '0;
            done_pulse   <= 1'b0;
            beat_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            beat_count <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // First beat of a new write: count restarts at one
                        r_beats <= CW'(1);
                        if (w_is_done) begin
                            r_state    <= S_CLOSE;
                            done_pulse <= 1'b1;
                            beat_count <= CW'(1);
                        end else begin
                            r_state <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_beats <= w_beats_nxt;
                        // Beat past the limit is still buffered, only flagged
                        if (r_beats == c_max_beats) begin
                            err_overflow <= 1'b1;
                        end
                        if (w_is_done) begin
                            r_state    <= S_CLOSE;
                            done_pulse <= 1'b1;
                            beat_count <= w_beats_nxt;
                        end
                    end
                end
                S_CLOSE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for the reserved cycle encoding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_proto <= 1'b0;
        end else if (in_cycle == RSVD) begin
            err_proto <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/hero_write_rx.md
HERO_WRITE_RX -- requirements
Module: hero_write_rx

Interface
REQ-001 Parameter HERO_WIDTH, default 32, SHALL set the hero bus data width.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two >= 2, SHALL set the beat buffer depth.
REQ-003 Parameter MAX_BEATS, default 16, SHALL set the maximum legal beats per write, DONE beat included.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 Port list SHALL be:
 - clk  in  1  rising-edge clock.
 - rst  in  1  asynchronous active-high reset.
 - in_cycle  in  CYCLE_TYPE_E (2)  hero cycle type: IDLE, VALID or DONE.
 - in_data  in  HERO_WIDTH  hero write data beat.
 - in_ready  out  1  receiver can accept a beat this cycle.
 - out_valid  out  1  FIFO head valid.
 - out_data  out  HERO_WIDTH  FIFO head data.
 - out_last  out  1  FIFO head is the DONE beat.
 - out_ready  in  1  downstream pops the head when out_valid is high.
 - done_pulse  out  1  one-cycle pulse marking write completion.
 - beat_count  out  $clog2(MAX_BEATS+1)  beats in the completed write; valid while done_pulse is high.
 - err_proto  out  1  sticky protocol error.
 - err_overflow  out  1  sticky beat-limit error.

Function
REQ-006 A beat SHALL be accepted when in_ready=1 and in_cycle is VALID or DONE; IDLE beats are never accepted.
REQ-007 FSM states SHALL be S_IDLE, S_RECV and S_CLOSE.
 - S_IDLE -> S_RECV on an accepted VALID beat.
 - S_IDLE -> S_CLOSE on an accepted DONE beat (single-beat write).
 - S_RECV -> S_CLOSE on an accepted DONE beat.
 - S_CLOSE -> S_IDLE unconditionally after one cycle.
REQ-008 in_ready SHALL be 1 only when the FIFO is not full (registered count) and the state is not S_CLOSE.
REQ-009 Each accepted beat SHALL be pushed with last = (in_cycle==DONE).
REQ-010 out_valid SHALL rise no earlier than one cycle after the push: no bypass path.
REQ-011 A pop SHALL occur when out_valid and out_ready are both 1.
REQ-012 A simultaneous push and pop SHALL leave the occupancy unchanged, including when empty-then-pushed is not yet visible.
REQ-013 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 The beat counter SHALL clear on entry to S_RECV/S_CLOSE from S_IDLE, increment per accepted beat and saturate at MAX_BEATS.
REQ-015 done_pulse SHALL be 1 exactly during S_CLOSE, with beat_count holding the final count; beat_count SHALL be 0 at all other times.
REQ-016 err_overflow SHALL set when a beat is accepted with the counter already at MAX_BEATS; that beat is still pushed.
REQ-017 err_proto SHALL set when in_cycle equals the reserved encoding 3; that beat is treated as IDLE and not accepted.
REQ-018 err_proto and err_overflow SHALL clear only on rst.

Reset
REQ-019 rst SHALL asynchronously force:
 - state=S_IDLE and FIFO pointers/count=0.
 - out_valid=0, out_last=0, out_data=0.
 - done_pulse=0, beat_count=0.
 - err_proto=0, err_overflow=0.
 - in_ready=0 while rst is asserted, and 1 the first cycle after release.
REQ-020 Reset mid-write SHALL discard all buffered beats; no done_pulse is generated for the aborted write.

Structure
REQ-021 CYCLE_TYPE_E (IDLE=0, VALID=1, DONE=2, 3 reserved), HERO_WIDTH and hero_write_t SHALL come from the shared test_pkg_a package; the FSM state enum SHALL live in that package too.
REQ-022 The buffer SHALL be a sub-module hero_rx_fifo (data+last, count-based full/empty), instantiated once.

Verification
REQ-023 VALID A1, VALID A2, DONE A3 with out_ready=1 -> out sequence A1, A2, A3(last=1); done_pulse once with beat_count=3.
REQ-024 Single DONE 0x55 from idle -> S_CLOSE next cycle; done_pulse with beat_count=1; out_last=1.
REQ-025 out_ready=0, 8 VALID beats (depth 8) -> in_ready=0 after the 8th; a 9th beat held; in_ready=1 the cycle after one pop.
REQ-026 17 beats with MAX_BEATS=16 -> err_overflow=1 from the 17th acceptance; beat_count=16 on done_pulse.
REQ-027 in_cycle=3 mid-write -> err_proto=1; no push; write completes normally afterwards.
REQ-028 rst asserted after 2 VALID beats -> outputs zero immediately; no done_pulse; the next write counts from 1.
